// File: rtl/perceptron_comm_ctrl_pkg.sv
// Shared constants for the perceptron packet controller: opcodes, FSM state codes and
// response lengths.
package perceptron_comm_ctrl_pkg;

    // Packet opcodes; the opcode is always the first byte of a packet.
    localparam logic [7:0] OpRead         = 8'd5;
    localparam logic [7:0] OpWriteWeights = 8'd50;
    localparam logic [7:0] OpWriteInputs  = 8'd51;
    localparam logic [7:0] OpReadResp     = 8'd100;
    localparam logic [7:0] OpRespOk       = 8'd101;
    localparam logic [7:0] OpRespErr      = 8'd102;

    // Acknowledge responses are a single opcode byte.
    localparam int unsigned RespLenAck = 1;

    // State codes are visible on cont_state, so the encoding is fixed.
    typedef enum logic [4:0] {
        StIdle       = 5'd0,
        StRxPayload  = 5'd1,
        StCommit     = 5'd2,
        StTxLoad     = 5'd3,
        StTxWaitBusy = 5'd4,
        StTxWaitDone = 5'd5
    } state_e;

    // Read response: opcode, weight1, weight2, result.
    function automatic int unsigned resp_len_read(input int unsigned nb);
        return 1 + 3 * nb;
    endfunction

endpackage

// File: rtl/perceptron_comm_ctrl_if.sv
// Byte-UART side of the perceptron packet controller. The controller uses the master
// modport; the UART (or a model of it) uses the slave modport.
interface perceptron_comm_ctrl_if;
    logic       rx_new_value;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        input  rx_new_value,
        input  rx_data,
        input  rx_error,
        input  tx_busy,
        output tx_start,
        output tx_data
    );

    modport slave (
        output rx_new_value,
        output rx_data,
        output rx_error,
        output tx_busy,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/perceptron_comm_ctrl_tx.sv
// Response serialiser: latches a response buffer on a load pulse and hands it byte by
// byte to the UART transmitter using the tx_start / tx_busy handshake.
module perceptron_comm_ctrl_tx
    import perceptron_comm_ctrl_pkg::*;
#(
    parameter int unsigned BufLen = 7,
    parameter int unsigned LenW   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic [LenW-1:0]        i_len,
    input  logic [BufLen-1:0][7:0] i_buf,
    input  logic                   i_tx_busy,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    output logic                   o_done,
    output state_e                 o_state
);

    state_e                 r_state;
    logic [BufLen-1:0][7:0] r_buf;
    logic [LenW-1:0]        r_len;
    logic [LenW-1:0]        r_idx;
    logic                   w_last;

    assign w_last = (r_idx == r_len - LenW'(1));

    // Handshake FSM: load byte, wait for the UART to go busy, wait for it to finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_buf   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_load) begin
                        r_buf   <= i_buf;
                        r_len   <= i_len;
                        r_idx   <= '0;
                        r_state <= StTxLoad;
                    end
                end
                StTxLoad: begin
                    if (!i_tx_busy) begin
                        r_state <= StTxWaitBusy;
                    end
                end
                StTxWaitBusy: begin
                    if (i_tx_busy) begin
                        r_state <= StTxWaitDone;
                    end
                end
                StTxWaitDone: begin
                    if (!i_tx_busy) begin
                        if (w_last) begin
                            r_state <= StIdle;
                        end else begin
                            r_idx   <= r_idx + LenW'(1);
                            r_state <= StTxLoad;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // tx_data comes from the buffer register, so it holds until the index advances.
    assign o_tx_start = (r_state == StTxLoad) && !i_tx_busy;
    assign o_tx_data  = r_buf[r_idx];
    assign o_done     = (r_state == StTxWaitDone) && !i_tx_busy && w_last;
    assign o_state    = r_state;

endmodule

// File: rtl/perceptron_comm_ctrl.sv
// Packet controller between the byte UART and the perceptron core: parses opcode
// packets, loads weight/input registers and sends read-back / acknowledge packets.
// Optional build macro COMM_RX_TIMEOUT_EN adds an inter-byte timeout in RX_PAYLOAD.
module perceptron_comm_ctrl
    import perceptron_comm_ctrl_pkg::*;
#(
    parameter int unsigned FpIntegerWidth = 4,
    parameter int unsigned FpFractWidth   = 12
`ifdef COMM_RX_TIMEOUT_EN
    ,
    parameter int unsigned TimeoutCycles  = 120000
`endif
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    perceptron_comm_ctrl_if.master                 uart,
    output logic [FpIntegerWidth+FpFractWidth-1:0] o_weight1,
    output logic [FpIntegerWidth+FpFractWidth-1:0] o_weight2,
    output logic [FpIntegerWidth+FpFractWidth-1:0] o_input1,
    output logic [FpIntegerWidth+FpFractWidth-1:0] o_input2,
    output logic                                   o_weights_load,
    output logic                                   o_inputs_load,
    input  logic [FpIntegerWidth+FpFractWidth-1:0] i_result,
    output logic [4:0]                             o_cont_state
);

    localparam int unsigned W      = FpIntegerWidth + FpFractWidth;
    localparam int unsigned NB     = W / 8;
    localparam int unsigned BufLen = resp_len_read(NB);
    localparam int unsigned LenW   = $clog2(BufLen + 1);
    localparam int unsigned CntW   = (2 * NB > 1) ? $clog2(2 * NB) : 1;

    // StTxLoad in r_state means "response in flight"; the sub-module owns the detail.
    state_e                 r_state;
    logic [2*W-1:0]         r_stage;
    logic [CntW-1:0]        r_cnt;
    logic                   r_tgt_weights;
    logic [W-1:0]           r_weight1;
    logic [W-1:0]           r_weight2;
    logic [W-1:0]           r_input1;
    logic [W-1:0]           r_input2;
    logic                   r_weights_load;
    logic                   r_inputs_load;

    logic                   w_byte;
    logic                   w_last_byte;
    logic                   w_timeout;
    logic                   w_abort;
    logic                   w_tx_load;
    logic [LenW-1:0]        w_tx_len;
    logic [BufLen-1:0][7:0] w_tx_buf;
    logic                   w_tx_done;
    state_e                 w_tx_state;

    // A framing error on the same cycle as a byte invalidates that byte.
    assign w_byte      = uart.rx_new_value && !uart.rx_error;
    assign w_last_byte = (r_cnt == CntW'(2 * NB - 1));

`ifdef COMM_RX_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TimeoutCycles + 1);
    logic [TmrW-1:0] r_timer;

    // Inter-byte timer: runs only while waiting for payload, restarts on every byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (r_state != StRxPayload || uart.rx_new_value) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TmrW'(1);
        end
    end

    assign w_timeout = (r_state == StRxPayload) && !uart.rx_new_value &&
                       (r_timer == TmrW'(TimeoutCycles - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_abort = (r_state == StRxPayload) && (uart.rx_error || w_timeout);

    // Response selection; the sub-module latches it on the same edge the FSM leaves.
    always_comb begin
        w_tx_load   = 1'b0;
        w_tx_len    = LenW'(RespLenAck);
        w_tx_buf    = '0;
        w_tx_buf[0] = OpRespErr;
        case (r_state)
            StIdle: begin
                if (w_byte && uart.rx_data != OpWriteWeights &&
                    uart.rx_data != OpWriteInputs) begin
                    w_tx_load = 1'b1;
                    if (uart.rx_data == OpRead) begin
                        w_tx_len    = LenW'(BufLen);
                        w_tx_buf[0] = OpReadResp;
                        for (int i = 0; i < NB; i++) begin
                            w_tx_buf[1 + i]          = r_weight1[W - 1 - 8 * i -: 8];
                            w_tx_buf[1 + NB + i]     = r_weight2[W - 1 - 8 * i -: 8];
                            w_tx_buf[1 + 2 * NB + i] = i_result[W - 1 - 8 * i -: 8];
                        end
                    end
                end
            end
            StRxPayload: begin
                w_tx_load = w_abort;
            end
            StCommit: begin
                w_tx_load   = 1'b1;
                w_tx_buf[0] = OpRespOk;
            end
            default: ;
        endcase
    end

    // Packet FSM: decode opcode, collect payload, commit, then wait for the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_stage        <= '0;
            r_cnt          <= '0;
            r_tgt_weights  <= 1'b0;
            r_weight1      <= '0;
            r_weight2      <= '0;
            r_input1       <= '0;
            r_input2       <= '0;
            r_weights_load <= 1'b0;
            r_inputs_load  <= 1'b0;
        end else begin
            r_weights_load <= 1'b0;
            r_inputs_load  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_byte) begin
                        if (uart.rx_data == OpWriteWeights ||
                            uart.rx_data == OpWriteInputs) begin
                            r_cnt         <= '0;
                            r_stage       <= '0;
                            r_tgt_weights <= (uart.rx_data == OpWriteWeights);
                            r_state       <= StRxPayload;
                        end else begin
                            r_state <= StTxLoad;
                        end
                    end
                end
                StRxPayload: begin
                    if (w_abort) begin
                        r_stage <= '0;
                        r_cnt   <= '0;
                        r_state <= StTxLoad;
                    end else if (uart.rx_new_value) begin
                        r_stage <= {r_stage[2*W-9:0], uart.rx_data};
                        r_cnt   <= r_cnt + CntW'(1);
                        if (w_last_byte) begin
                            r_state <= StCommit;
                        end
                    end
                end
                StCommit: begin
                    if (r_tgt_weights) begin
                        r_weight1      <= r_stage[2*W-1:W];
                        r_weight2      <= r_stage[W-1:0];
                        r_weights_load <= 1'b1;
                    end else begin
                        r_input1      <= r_stage[2*W-1:W];
                        r_input2      <= r_stage[W-1:0];
                        r_inputs_load <= 1'b1;
                    end
                    r_stage <= '0;
                    r_state <= StTxLoad;
                end
                StTxLoad: begin
                    if (w_tx_done) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    perceptron_comm_ctrl_tx #(
        .BufLen (BufLen),
        .LenW   (LenW)
    ) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tx_load),
        .i_len      (w_tx_len),
        .i_buf      (w_tx_buf),
        .i_tx_busy  (uart.tx_busy),
        .o_tx_start (uart.tx_start),
        .o_tx_data  (uart.tx_data),
        .o_done     (w_tx_done),
        .o_state    (w_tx_state)
    );

    assign o_weight1      = r_weight1;
    assign o_weight2      = r_weight2;
    assign o_input1       = r_input1;
    assign o_input2       = r_input2;
    assign o_weights_load = r_weights_load;
    assign o_inputs_load  = r_inputs_load;
    assign o_cont_state   = (r_state == StTxLoad) ? w_tx_state : r_state;

endmodule

// File: tb/tb_perceptron_comm_ctrl.sv
// Directed bench for perceptron_comm_ctrl (W=16) with a simple UART transmitter model.
module tb_perceptron_comm_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] w1, w2, in1, in2;
    logic [15:0] result;
    logic        wl, il;
    logic [4:0]  cs;

    int          n_pass = 0;
    int          n_total = 0;
    int          wl_cnt = 0;
    int          il_cnt = 0;
    logic [7:0]  cap_q[$];

    perceptron_comm_ctrl_if u_if ();

    perceptron_comm_ctrl #(
        .FpIntegerWidth (4),
        .FpFractWidth   (12)
`ifdef COMM_RX_TIMEOUT_EN
        ,
        .TimeoutCycles  (200)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .uart           (u_if),
        .o_weight1      (w1),
        .o_weight2      (w2),
        .o_input1       (in1),
        .o_input2       (in2),
        .o_weights_load (wl),
        .o_inputs_load  (il),
        .i_result       (result),
        .o_cont_state   (cs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART transmitter model: capture on tx_start, stay busy for a few cycles.
    initial begin
        u_if.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (u_if.tx_start === 1'b1) begin
                cap_q.push_back(u_if.tx_data);
                @(posedge clk);
                #1 u_if.tx_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 u_if.tx_busy = 1'b0;
            end
        end
    end

    // Count load pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (wl === 1'b1) wl_cnt++;
            if (il === 1'b1) il_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        u_if.rx_new_value = 1'b1;
        u_if.rx_data      = b;
        @(posedge clk);
        #1;
        u_if.rx_new_value = 1'b0;
    endtask

    task automatic send_err(input logic [7:0] b, input bit with_byte);
        @(posedge clk);
        #1;
        u_if.rx_error     = 1'b1;
        u_if.rx_new_value = with_byte;
        u_if.rx_data      = b;
        @(posedge clk);
        #1;
        u_if.rx_error     = 1'b0;
        u_if.rx_new_value = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (cs == 5'd0 && u_if.tx_busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        u_if.rx_new_value = 1'b0;
        u_if.rx_data      = 8'h00;
        u_if.rx_error     = 1'b0;
        result            = 16'h1000;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (u_if.tx_start !== 1'b0) $display("FAIL reset tx_start: got %b want 0", u_if.tx_start); else n_pass++;
        n_total++; if (u_if.tx_data !== 8'h00) $display("FAIL reset tx_data: got %h want 00", u_if.tx_data); else n_pass++;
        n_total++; if (w1 !== 16'h0 || w2 !== 16'h0) $display("FAIL reset weights: got %h %h want 0000 0000", w1, w2); else n_pass++;
        n_total++; if (in1 !== 16'h0 || in2 !== 16'h0) $display("FAIL reset inputs: got %h %h want 0000 0000", in1, in2); else n_pass++;
        n_total++; if (wl !== 1'b0 || il !== 1'b0) $display("FAIL reset loads: got %b %b want 0 0", wl, il); else n_pass++;
        n_total++; if (cs !== 5'd0) $display("FAIL reset cont_state: got %0d want 0", cs); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_read_initial();
        logic [7:0] exp [7];
        logic [7:0] g;
        bit         ok;
        exp = '{8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00};
        cap_q.delete();
        send_byte(8'd5);
        wait_idle(ok);
        n_total++; if (!ok) $display("FAIL read0 idle: got busy want idle"); else n_pass++;
        n_total++; if (cap_q.size() != 7) $display("FAIL read0 length: got %0d want 7", cap_q.size()); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            g = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
            n_total++; if (g !== exp[i]) $display("FAIL read0 byte %0d: got %h want %h", i, g, exp[i]); else n_pass++;
        end
    endtask

    task automatic test_write_weights();
        logic [7:0] exp [7];
        logic [7:0] g;
        bit         ok;
        int         wl0, il0;
        wl0 = wl_cnt;
        il0 = il_cnt;
        cap_q.delete();
        send_byte(8'd50);
        send_byte(8'h15);
        send_byte(8'hAA);
        send_byte(8'hFC);
        send_byte(8'h33);
        // Now in COMMIT: targets not yet updated.
        n_total++; if (cs !== 5'd2) $display("FAIL ww commit state: got %0d want 2", cs); else n_pass++;
        n_total++; if (w1 !== 16'h0000) $display("FAIL ww early update: got %h want 0000", w1); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (cs !== 5'd3) $display("FAIL ww txload state: got %0d want 3", cs); else n_pass++;
        n_total++; if (u_if.tx_start !== 1'b1) $display("FAIL ww latency tx_start: got %b want 1", u_if.tx_start); else n_pass++;
        n_total++; if (wl !== 1'b1) $display("FAIL ww load pulse: got %b want 1", wl); else n_pass++;
        n_total++; if (w1 !== 16'h15AA || w2 !== 16'hFC33) $display("FAIL ww weights: got %h %h want 15aa fc33", w1, w2); else n_pass++;
        wait_idle(ok);
        n_total++; if (!ok) $display("FAIL ww idle: got busy want idle"); else n_pass++;
        n_total++; if (cap_q.size() != 1 || cap_q[0] !== 8'h65) $display("FAIL ww resp: got %0d bytes first %h want 1 bytes 65", cap_q.size(), cap_q[0]); else n_pass++;
        n_total++; if (wl_cnt - wl0 != 1 || il_cnt != il0) $display("FAIL ww pulse count: got %0d %0d want 1 0", wl_cnt - wl0, il_cnt - il0); else n_pass++;
        exp = '{8'h64, 8'h15, 8'hAA, 8'hFC, 8'h33, 8'h10, 8'h00};
        cap_q.delete();
        send_byte(8'd5);
        wait_idle(ok);
        n_total++; if (cap_q.size() != 7) $display("FAIL readback length: got %0d want 7", cap_q.size()); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            g = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
            n_total++; if (g !== exp[i]) $display("FAIL readback byte %0d: got %h want %h", i, g, exp[i]); else n_pass++;
        end
    endtask

    task automatic test_write_inputs();
        bit ok;
        int wl0, il0;
        wl0 = wl_cnt;
        il0 = il_cnt;
        cap_q.delete();
        send_byte(8'd51);
        send_byte(8'hE0);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h0F);
        wait_idle(ok);
        n_total++; if (!ok) $display("FAIL wi idle: got busy want idle"); else n_pass++;
        n_total++; if (cap_q.size() != 1 || cap_q[0] !== 8'h65) $display("FAIL wi resp: got %0d bytes first %h want 1 bytes 65", cap_q.size(), cap_q[0]); else n_pass++;
        n_total++; if (in1 !== 16'hE000 || in2 !== 16'h200F) $display("FAIL wi inputs: got %h %h want e000 200f", in1, in2); else n_pass++;
        n_total++; if (w1 !== 16'h15AA || w2 !== 16'hFC33) $display("FAIL wi weights kept: got %h %h want 15aa fc33", w1, w2); else n_pass++;
        n_total++; if (il_cnt - il0 != 1 || wl_cnt != wl0) $display("FAIL wi pulse count: got %0d %0d want 1 0", il_cnt - il0, wl_cnt - wl0); else n_pass++;
    endtask

    task automatic test_bad_opcode();
        bit ok;
        int wl0, il0;
        wl0 = wl_cnt;
        il0 = il_cnt;
        cap_q.delete();
        send_byte(8'd7);
        wait_idle(ok);
        n_total++; if (cap_q.size() != 1 || cap_q[0] !== 8'h66) $display("FAIL bad op resp: got %0d bytes first %h want 1 bytes 66", cap_q.size(), cap_q[0]); else n_pass++;
        n_total++; if (w1 !== 16'h15AA || in1 !== 16'hE000) $display("FAIL bad op regs: got %h %h want 15aa e000", w1, in1); else n_pass++;
        n_total++; if (wl_cnt != wl0 || il_cnt != il0) $display("FAIL bad op pulses: got %0d %0d want 0 0", wl_cnt - wl0, il_cnt - il0); else n_pass++;
    endtask

    task automatic test_rx_error();
        bit ok;
        int wl0;
        wl0 = wl_cnt;
        // Error ignored in IDLE.
        cap_q.delete();
        send_err(8'h00, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        n_total++; if (cs !== 5'd0 || cap_q.size() != 0) $display("FAIL idle error: got state %0d bytes %0d want 0 0", cs, cap_q.size()); else n_pass++;
        // Error mid-packet, arriving together with a byte.
        send_byte(8'd50);
        send_byte(8'h11);
        send_err(8'h22, 1'b1);
        wait_idle(ok);
        n_total++; if (!ok) $display("FAIL rx err idle: got busy want idle"); else n_pass++;
        n_total++; if (cap_q.size() != 1 || cap_q[0] !== 8'h66) $display("FAIL rx err resp: got %0d bytes first %h want 1 bytes 66", cap_q.size(), cap_q[0]); else n_pass++;
        n_total++; if (w1 !== 16'h15AA || w2 !== 16'hFC33) $display("FAIL rx err weights: got %h %h want 15aa fc33", w1, w2); else n_pass++;
        n_total++; if (wl_cnt != wl0) $display("FAIL rx err pulse: got %0d want 0", wl_cnt - wl0); else n_pass++;
        // A fresh full packet after the abort is accepted intact.
        cap_q.delete();
        send_byte(8'd50);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        wait_idle(ok);
        n_total++; if (cap_q.size() != 1 || cap_q[0] !== 8'h65) $display("FAIL after err resp: got %0d bytes first %h want 1 bytes 65", cap_q.size(), cap_q[0]); else n_pass++;
        n_total++; if (w1 !== 16'h0102 || w2 !== 16'h0304) $display("FAIL after err weights: got %h %h want 0102 0304", w1, w2); else n_pass++;
    endtask

    task automatic test_drop_during_tx();
        logic [7:0] exp [7];
        logic [7:0] g;
        bit         ok;
        exp = '{8'h64, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h00};
        cap_q.delete();
        send_byte(8'd5);
        repeat (4) @(posedge clk);
        send_byte(8'd7);
        wait_idle(ok);
        repeat (30) @(posedge clk);
        #1;
        n_total++; if (cap_q.size() != 7) $display("FAIL drop length: got %0d want 7", cap_q.size()); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            g = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
            n_total++; if (g !== exp[i]) $display("FAIL drop byte %0d: got %h want %h", i, g, exp[i]); else n_pass++;
        end
    endtask

`ifdef COMM_RX_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int il0;
        il0 = il_cnt;
        cap_q.delete();
        send_byte(8'd51);
        send_byte(8'h01);
        wait_idle(ok);
        n_total++; if (!ok) $display("FAIL timeout idle: got busy want idle"); else n_pass++;
        n_total++; if (cap_q.size() != 1 || cap_q[0] !== 8'h66) $display("FAIL timeout resp: got %0d bytes first %h want 1 bytes 66", cap_q.size(), cap_q[0]); else n_pass++;
        n_total++; if (in1 !== 16'hE000 || in2 !== 16'h200F) $display("FAIL timeout inputs: got %h %h want e000 200f", in1, in2); else n_pass++;
        n_total++; if (il_cnt != il0) $display("FAIL timeout pulse: got %0d want 0", il_cnt - il0); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_response();
        bit seen;
        bit start_seen;
        cap_q.delete();
        send_byte(8'd5);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (cap_q.size() >= 1) begin
                seen = 1'b1;
                break;
            end
        end
        n_total++; if (!seen) $display("FAIL midrst first byte: got none want 1"); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (u_if.tx_start !== 1'b0) $display("FAIL midrst tx_start: got %b want 0", u_if.tx_start); else n_pass++;
        n_total++; if (cs !== 5'd0) $display("FAIL midrst state: got %0d want 0", cs); else n_pass++;
        n_total++; if (w1 !== 16'h0000) $display("FAIL midrst weight1: got %h want 0000", w1); else n_pass++;
        start_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (u_if.tx_start !== 1'b0) start_seen = 1'b1;
        end
        n_total++; if (start_seen) $display("FAIL midrst start in reset: got 1 want 0"); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        n_total++; if (cap_q.size() != 1 || cs !== 5'd0) $display("FAIL midrst after: got %0d bytes state %0d want 1 0", cap_q.size(), cs); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read_initial();
        test_write_weights();
        test_write_inputs();
        test_bad_opcode();
        test_rx_error();
        test_drop_during_tx();
`ifdef COMM_RX_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_response();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
